arm_fetch_queue: RTL
====================

// Module: arm_fetch_queue
// PURPOSE
//  Instruction fetch front-end that feeds the pipelined ARM core's PC/IC inputs (IF stage source).
//  Issues in-order word requests to instruction memory over a valid/ready handshake.
//  Buffers returned instructions with their PCs in a DEPTH-entry queue and flushes on branch redirect.
//  Presents one {PC, IC} pair per cycle to the core, holding it while the core stalls.
// PARAMETERS
//  DEPTH     4       queue entries; also the maximum number of in-flight requests (power of 2, >=2)
//  ADDR_W    64      PC / address width
//  RESET_PC  64'h0   first fetch address after reset
// PORTS
//  CLOCK          in   1       single clock; all state updates on posedge
//  RESET          in   1       asynchronous, active-low reset
//  imem_req_valid out  1       request to instruction memory is valid
//  imem_req_ready in   1       memory accepts the request this cycle
//  imem_req_addr  out  ADDR_W  byte address of the requested word
//  imem_rsp_valid in   1       response word valid; responses return in request order
//  imem_rsp_data  in   32      instruction word
//  redirect       in   1       branch taken (core PCSrc); flush the queue and refetch
//  redirect_pc    in   ADDR_W  branch target address
//  stall          in   1       core cannot consume PC/IC this cycle
//  PC             out  ADDR_W  PC of the presented instruction
//  IC             out  32      presented instruction; 32'h0 (bubble) when ic_valid=0
//  ic_valid       out  1       PC/IC hold a real instruction
// BEHAVIOUR
//  Reset (RESET=0, async):
//   - queue empty; in-flight=0; discard=0; state=RUN; fetch_pc=RESET_PC
//   - imem_req_valid=0, PC=0, IC=0, ic_valid=0
//  Counters and credit:
//   - in-flight: accepted requests whose response has not yet returned (0..DEPTH)
//   - credit: occupancy + in-flight < DEPTH
//  Request issue:
//   - imem_req_valid=1 iff state=RUN and credit is available
//   - imem_req_addr=fetch_pc; the address is held stable while valid=1 and ready=0
//   - on accept (valid & ready): fetch_pc += 4 (wraps modulo 2^ADDR_W) and in-flight += 1
//  Response:
//   - every imem_rsp_valid decrements in-flight
//   - if discard>0: decrement discard and drop the word
//   - otherwise push {pc_tag, data}; pc_tag is the PC recorded at request time (PC FIFO of DEPTH)
//   - a pushed entry is visible at the queue head on the next cycle; there is no same-cycle bypass
//  Output:
//   - PC/IC/ic_valid are registered and come from the queue head
//   - pop when ic_valid & !stall
//   - when the queue is empty: ic_valid=0, IC=32'h0, and PC holds its last value
//   - with a 1-cycle-latency memory, the first valid instruction appears 3 cycles after RESET rises
//  Redirect (highest priority, evaluated at the clock edge):
//   - queue cleared, ic_valid=0 next cycle; redirect takes effect even when stall=1
//   - fetch_pc=redirect_pc
//   - discard = in-flight after this cycle's accept/response updates
//     (a request accepted in the redirect cycle is discarded; a response arriving in the redirect cycle is dropped)
//   - next state = DRAIN if discard>0, else RUN
//  FSM:
//   - RUN: issue requests normally
//   - DRAIN: no requests issued; go to RUN in the cycle discard reaches 0
//   - a redirect during DRAIN reloads fetch_pc and keeps counting the existing discard
//  Boundaries:
//   - queue full: no issue because credit=0
//   - push and pop in the same cycle: occupancy unchanged
//   - response with in-flight=0: protocol error; ignored (assertion in simulation)
//   - reset mid-transfer: all state cleared; late memory responses after reset count as in-flight=0 and are ignored
// TESTING
//  1. Reset, 1-cycle memory, stall=0
//     -> requests at 0,4,8,12; ic_valid first high on the 3rd cycle after reset release; PC sequence 0,4,8 with matching IC.
//  2. stall=1 for 10 cycles
//     -> exactly 4 requests issued, then imem_req_valid=0; PC/IC held; on release, 4 pops in 4 cycles, then issue resumes.
//  3. imem_req_ready=0 for 3 cycles
//     -> imem_req_addr stable at the same value; fetch_pc advances only on the accept.
//  4. redirect to 0x100 with 2 requests in flight
//     -> state=DRAIN; the 2 responses are dropped; the next request is 0x100; the next valid PC=0x100.
//  5. redirect in the same cycle as a response and an accept
//     -> the response is not visible; the accepted request is discarded; no stale IC reaches the output.
//  6. RESET pulsed low mid-stream with 2 in flight
//     -> outputs zero immediately; the post-reset fetch starts at RESET_PC; late responses are ignored.

Source files
------------

// File: rtl/arm_fetch_queue_if.sv
// rtl/arm_fetch_queue_if.sv - instruction-memory, redirect and core-facing bundle of the fetch queue
//
// master: the fetch queue (drives imem requests and the PC/IC/ic_valid presentation)
// slave : memory + core side (drives ready, responses, redirect and stall)
interface arm_fetch_queue_if #(
    parameter int ADDR_W = 64
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    logic [ADDR_W-1:0] PC;
    logic [31:0]       IC;
    logic              ic_valid;

    modport master (
        output imem_req_valid, imem_req_addr, PC, IC, ic_valid,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, PC, IC, ic_valid,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/arm_fetch_queue.sv
// rtl/arm_fetch_queue.sv - in-order instruction fetch queue feeding the core's PC/IC inputs
//
// Ports:
//   CLOCK  in  single clock, all state updates on the rising edge
//   RESET  in  asynchronous active-low reset
//   bus    arm_fetch_queue_if.master
//            imem_req_valid/ready/addr  word requests to instruction memory
//            imem_rsp_valid/data        in-order responses
//            redirect/redirect_pc       branch redirect (flush + refetch)
//            stall                      core cannot consume this cycle
//            PC/IC/ic_valid             registered instruction presented to the core
module arm_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               CLOCK,
    input logic               RESET,
    arm_fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     q_cnt;
    logic [PW-1:0]     tag_wr, tag_rd;
    logic [PW-1:0]     q_wr, q_rd;

    logic [ADDR_W-1:0] tag_mem [DEPTH];
    logic [ADDR_W-1:0] q_pc    [DEPTH];
    logic [31:0]       q_ic    [DEPTH];

    logic              credit, accept, rsp_ok, drop, push, pop, load;
    logic [SW-1:0]     committed;
    logic [CW-1:0]     in_flight_nxt, discard_nxt;

    // The presented entry (ic_valid) counts toward occupancy, so DEPTH
    // bounds everything the fetcher has committed to: presented, queued
    // and still in memory.
    always_comb begin
        committed     = SW'(q_cnt) + SW'(bus.ic_valid) + SW'(in_flight);
        credit        = committed < SW'(DEPTH);
        accept        = bus.imem_req_valid && bus.imem_req_ready;
        // A response with nothing outstanding (e.g. one that straddled a
        // reset) has no matching tag and is ignored.
        rsp_ok        = bus.imem_rsp_valid && (in_flight != '0);
        drop          = rsp_ok && (discard != '0);
        push          = rsp_ok && !drop && !bus.redirect;
        pop           = bus.ic_valid && !bus.stall;
        load          = (q_cnt != '0) && (!bus.ic_valid || pop);
        in_flight_nxt = in_flight + CW'(accept) - CW'(rsp_ok);
        discard_nxt   = discard - CW'(drop);
    end

    // Gated by RESET so no request is shown while reset is held.
    assign bus.imem_req_valid = RESET && (state == RUN) && credit;
    assign bus.imem_req_addr  = fetch_pc;

    // Storage needs no reset: pointers and counts define what is live.
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            tag_mem[tag_wr] <= fetch_pc;
        end
        if (push) begin
            q_pc[q_wr] <= tag_mem[tag_rd];
            q_ic[q_wr] <= bus.imem_rsp_data;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= RUN;
            fetch_pc     <= RESET_PC;
            in_flight    <= '0;
            discard      <= '0;
            q_cnt        <= '0;
            tag_wr       <= '0;
            tag_rd       <= '0;
            q_wr         <= '0;
            q_rd         <= '0;
            bus.PC       <= '0;
            bus.IC       <= '0;
            bus.ic_valid <= 1'b0;
        end else begin
            in_flight <= in_flight_nxt;
            if (accept) begin
                tag_wr <= tag_wr + 1'b1;
            end
            if (rsp_ok) begin
                tag_rd <= tag_rd + 1'b1;
            end

            if (bus.redirect) begin
                // Everything still in memory after this edge belongs to the
                // wrong path, including a request accepted right now.
                fetch_pc     <= bus.redirect_pc;
                discard      <= in_flight_nxt;
                state        <= (in_flight_nxt != '0) ? DRAIN : RUN;
                q_cnt        <= '0;
                q_wr         <= '0;
                q_rd         <= '0;
                bus.ic_valid <= 1'b0;
                bus.IC       <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                discard <= discard_nxt;
                if (state == DRAIN && discard_nxt == '0) begin
                    state <= RUN;
                end
                if (push) begin
                    q_wr <= q_wr + 1'b1;
                end
                if (load) begin
                    bus.PC       <= q_pc[q_rd];
                    bus.IC       <= q_ic[q_rd];
                    bus.ic_valid <= 1'b1;
                    q_rd         <= q_rd + 1'b1;
                end else if (pop) begin
                    // PC keeps its last value on a bubble.
                    bus.ic_valid <= 1'b0;
                    bus.IC       <= '0;
                end
                q_cnt <= q_cnt + CW'(push) - CW'(load);
            end
        end
    end
endmodule
